// File: rtl/shiyan_13.sv
// Up/down counter with parallel load (active-low), count enable and terminal-count co.
// Define SHIYAN_13_CO_REG_EN to register co as a one-cycle "wrapped last edge" pulse.
module shiyan_13 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             load,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co
);

  logic at_term;
  logic wrap;

  // Terminal value depends on direction: all-ones going up, zero going down.
  assign at_term = up_dn ? (q == {WIDTH{1'b1}}) : (q == '0);
  assign wrap    = en & load & ~mr & at_term;

  always_ff @(posedge clk) begin
    if (mr)
      q <= '0;
    else if (!load)
      q <= d;
    else if (en)
      q <= up_dn ? q + WIDTH'(1) : q - WIDTH'(1);
  end

`ifdef SHIYAN_13_CO_REG_EN
  // Pulses the cycle after the wrapping edge; every non-wrapping edge clears it.
  always_ff @(posedge clk) begin
    if (mr) co <= 1'b0;
    else    co <= wrap;
  end
`else
  assign co = wrap;
`endif

endmodule

// File: tb/tb_shiyan_13.sv
// Directed self-checking bench for shiyan_13; co expectations follow the build macro.
module tb_shiyan_13;

  logic       clk = 1'b0;
  logic       mr, load, en, up_dn;
  logic [3:0] d;
  logic [3:0] q;
  logic       co;
  int         checks = 0;
  int         errors = 0;

  shiyan_13 #(.WIDTH(4)) dut (
    .clk(clk), .mr(mr), .load(load), .en(en), .up_dn(up_dn),
    .d(d), .q(q), .co(co)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ec_comb: expected co in the default build; ec_reg: with the registered co.
  task automatic check(input string tag, input logic [3:0] eq,
                       input logic ec_comb, input logic ec_reg);
    logic ec;
`ifdef SHIYAN_13_CO_REG_EN
    ec = ec_reg;
`else
    ec = ec_comb;
`endif
    checks++;
    assert (q === eq) else begin
      errors++;
      $error("FAIL %s q: got %0d expected %0d", tag, q, eq);
    end
    checks++;
    assert (co === ec) else begin
      errors++;
      $error("FAIL %s co: got %b expected %b", tag, co, ec);
    end
  endtask

  initial begin
    // Reset beats load
    mr = 1; load = 0; d = 4'd9; en = 1; up_dn = 1;
    tick(); check("reset", 4'd0, 1'b0, 1'b0);

    // Load then hold
    mr = 0; load = 0; d = 4'd3;
    tick(); check("load3", 4'd3, 1'b0, 1'b0);
    load = 1; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("hold", 4'd3, 1'b0, 1'b0);
    end

    // Count down through the 0 -> 15 wrap
    en = 1; up_dn = 0;
    tick(); check("dn2", 4'd2, 1'b0, 1'b0);
    tick(); check("dn1", 4'd1, 1'b0, 1'b0);
    tick(); check("dn0", 4'd0, 1'b1, 1'b0);
    tick(); check("dn15", 4'd15, 1'b0, 1'b1);

    // Count up through the 15 -> 0 wrap
    load = 0; d = 4'd13;
    tick(); check("load13", 4'd13, 1'b0, 1'b0);
    load = 1; up_dn = 1;
    tick(); check("up14", 4'd14, 1'b0, 1'b0);
    tick(); check("up15", 4'd15, 1'b1, 1'b0);
    tick(); check("up0", 4'd0, 1'b0, 1'b1);
    tick(); check("up1", 4'd1, 1'b0, 1'b0);

    // Direction and enable toggling
    load = 0; d = 4'd5;
    tick(); check("load5", 4'd5, 1'b0, 1'b0);
    load = 1; up_dn = 1;
    tick(); check("tog6", 4'd6, 1'b0, 1'b0);
    tick(); check("tog7", 4'd7, 1'b0, 1'b0);
    up_dn = 0;
    tick(); check("tog6b", 4'd6, 1'b0, 1'b0);
    en = 0;
    tick(); check("tog_hold", 4'd6, 1'b0, 1'b0);
    en = 1;
    tick(); check("tog5", 4'd5, 1'b0, 1'b0);

    // Mid-count reset
    load = 0; d = 4'd9; up_dn = 1;
    tick(); check("load9", 4'd9, 1'b0, 1'b0);
    load = 1;
    tick(); check("up10", 4'd10, 1'b0, 1'b0);
    mr = 1;
    tick(); check("midrst", 4'd0, 1'b0, 1'b0);
    mr = 0;
    tick(); check("resume1", 4'd1, 1'b0, 1'b0);
    tick(); check("resume2", 4'd2, 1'b0, 1'b0);

    // Load beats enable
    load = 0; en = 1; d = 4'd7;
    tick(); check("load_en", 4'd7, 1'b0, 1'b0);

    // Loaded terminal value: co follows en/load/mr combinationally
    d = 4'd15;
    tick(); check("load15_ld", 4'd15, 1'b0, 1'b0);
    load = 1; #1;
    check("term_co", 4'd15, 1'b1, 1'b0);
    en = 0; #1;
    check("term_en0", 4'd15, 1'b0, 1'b0);
    en = 1; mr = 1; #1;
    check("term_mr", 4'd15, 1'b0, 1'b0);
    mr = 0; up_dn = 0; #1;
    check("term_dir", 4'd15, 1'b0, 1'b0);
    up_dn = 1;
    tick(); check("wrap_after_load", 4'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
